verifica_tabuleiro: RTL and testbench

VERIFICA_TABULEIRO -- requirements
Module: verifica_tabuleiro

---
 rtl/verifica_tabuleiro.sv | 155 +++++++++++++++
 tb/tb_verifica_tabuleiro.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/verifica_tabuleiro.sv
// verifica_tabuleiro
//   Scans one 3x3 tic-tac-toe board out of a shared board memory and reports
//   the winner, a draw, and the winning line index.
//
//   Scan sequence: OCIOSO -> LEITURA (9 reads) -> ESPERA (last read lands)
//                  -> AVALIA (one line per cycle) -> FIM (pronto strobe).
//
//   Ports
//     clock      sole clock, rising edge
//     reset_n    asynchronous active-low reset
//     iniciar    start request, only honoured in OCIOSO
//     base       board index (0-8 micro, 9 macro), latched on start
//     endereco   board-memory read address, base*9+k during LEITURA, else 0
//     dado       cell code returned one cycle after endereco
//     ocupado    scan in progress
//     pronto     one-cycle result strobe (state FIM)
//     vencedor   00 none, 01 O, 10 X
//     empate     board full with no winner
//     linha      index of the first winning line
//     db_estado  current state code
//
//   Optional build macro: PARADA_ANTECIPADA_EN
//     When defined, a winning line ends AVALIA at once (pronto at 12+l cycles
//     after the start edge). Otherwise all 8 lines are checked and latency is
//     fixed at 19 cycles. Results are identical in both builds.
module verifica_tabuleiro (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       iniciar,
  input  logic [3:0] base,
  output logic [7:0] endereco,
  input  logic [1:0] dado,
  output logic       ocupado,
  output logic       pronto,
  output logic [1:0] vencedor,
  output logic       empate,
  output logic [2:0] linha,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    OCIOSO  = 4'h0,
    LEITURA = 4'h1,
    ESPERA  = 4'h2,
    AVALIA  = 4'h3,
    FIM     = 4'hF
  } estado_t;

  estado_t    estado;
  logic [3:0] k;
  logic [2:0] l;
  logic [3:0] base_q;
  logic [1:0] celula [0:8];

  logic [1:0] ca, cb, cc;
  logic       vitoria;
  logic       cheio;

  // Three cells of the line under test.
  always_comb begin
    ca = 2'b00;
    cb = 2'b00;
    cc = 2'b00;
    case (l)
      3'd0: begin ca = celula[0]; cb = celula[1]; cc = celula[2]; end
      3'd1: begin ca = celula[3]; cb = celula[4]; cc = celula[5]; end
      3'd2: begin ca = celula[6]; cb = celula[7]; cc = celula[8]; end
      3'd3: begin ca = celula[0]; cb = celula[3]; cc = celula[6]; end
      3'd4: begin ca = celula[1]; cb = celula[4]; cc = celula[7]; end
      3'd5: begin ca = celula[2]; cb = celula[5]; cc = celula[8]; end
      3'd6: begin ca = celula[0]; cb = celula[4]; cc = celula[8]; end
      default: begin ca = celula[2]; cb = celula[4]; cc = celula[6]; end
    endcase
  end

  // Only player codes win; 11 (blocked) three-in-a-row is not a win.
  assign vitoria = (ca == cb) && (cb == cc) && ((ca == 2'b01) || (ca == 2'b10));

  always_comb begin
    cheio = 1'b1;
    for (int i = 0; i < 9; i++)
      if (celula[i] == 2'b00) cheio = 1'b0;
  end

  // Moore outputs decoded from registered state only.
  assign endereco  = (estado == LEITURA) ? ({4'b0, base_q} * 8'd9 + {4'b0, k}) : 8'd0;
  assign ocupado   = (estado == LEITURA) || (estado == ESPERA) ||
                     (estado == AVALIA)  || (estado == FIM);
  assign pronto    = (estado == FIM);
  assign db_estado = estado;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado   <= OCIOSO;
      k        <= 4'd0;
      l        <= 3'd0;
      base_q   <= 4'd0;
      vencedor <= 2'b00;
      empate   <= 1'b0;
      linha    <= 3'd0;
      for (int i = 0; i < 9; i++) celula[i] <= 2'b00;
    end else begin
      case (estado)
        OCIOSO: begin
          if (iniciar) begin
            base_q   <= base;
            vencedor <= 2'b00;
            empate   <= 1'b0;
            linha    <= 3'd0;
            k        <= 4'd0;
            estado   <= LEITURA;
          end
        end
        LEITURA: begin
          // dado lags endereco by one cycle, so it belongs to cell k-1.
          if (k != 4'd0) celula[k - 4'd1] <= dado;
          if (k == 4'd8) begin
            k      <= 4'd0;
            estado <= ESPERA;
          end else begin
            k <= k + 4'd1;
          end
        end
        ESPERA: begin
          celula[8] <= dado;
          l         <= 3'd0;
          estado    <= AVALIA;
        end
        AVALIA: begin
          if (l == 3'd7) begin
            estado <= FIM;
            if (!vitoria && (vencedor == 2'b00) && cheio) empate <= 1'b1;
          end else begin
            l <= l + 3'd1;
          end
          // First winning line wins; later ones never overwrite it.
          if (vitoria && (vencedor == 2'b00)) begin
            vencedor <= ca;
            linha    <= l;
`ifdef PARADA_ANTECIPADA_EN
            estado   <= FIM;
`endif
          end
        end
        FIM: begin
          estado <= OCIOSO;
        end
        default: begin
          estado <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_verifica_tabuleiro.sv
module tb_verifica_tabuleiro;

  logic       clock;
  logic       reset_n;
  logic       iniciar;
  logic [3:0] base;
  logic [7:0] endereco;
  logic [1:0] dado;
  logic       ocupado;
  logic       pronto;
  logic [1:0] vencedor;
  logic       empate;
  logic [2:0] linha;
  logic [3:0] db_estado;

  int errors = 0;
  int checks = 0;

  logic [1:0] mem [0:255];
  logic [1:0] board [9];
  int         lt [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                            '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  logic [1:0] exp_v;
  logic       exp_e;
  logic [2:0] exp_l;
  int         exp_lat;

  verifica_tabuleiro dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .iniciar  (iniciar),
    .base     (base),
    .endereco (endereco),
    .dado     (dado),
    .ocupado  (ocupado),
    .pronto   (pronto),
    .vencedor (vencedor),
    .empate   (empate),
    .linha    (linha),
    .db_estado(db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous-read board memory: data appears one cycle after the address.
  always @(posedge clock) dado <= mem[endereco];

  // Reference: scan lines in order, first winner, draw if full and no winner.
  function automatic void modelo();
    bit full;
    exp_v = 2'b00; exp_l = 3'd0; exp_e = 1'b0;
    exp_lat = 19;
    for (int i = 0; i < 8; i++) begin
      logic [1:0] a, b, c;
      a = board[lt[i][0]]; b = board[lt[i][1]]; c = board[lt[i][2]];
      if (exp_v == 2'b00 && a == b && b == c && (a == 2'b01 || a == 2'b10)) begin
        exp_v = a;
        exp_l = 3'(i);
`ifdef PARADA_ANTECIPADA_EN
        exp_lat = 12 + i;
`endif
      end
    end
    full = 1;
    for (int i = 0; i < 9; i++) if (board[i] == 2'b00) full = 0;
    if (exp_v == 2'b00 && full) exp_e = 1'b1;
  endfunction

  function automatic void set_board(input int c0, c1, c2, c3, c4, c5, c6, c7, c8);
    board[0] = 2'(c0); board[1] = 2'(c1); board[2] = 2'(c2);
    board[3] = 2'(c3); board[4] = 2'(c4); board[5] = 2'(c5);
    board[6] = 2'(c6); board[7] = 2'(c7); board[8] = 2'(c8);
  endfunction

  // One full scan of board[] at base b; iniciar re-pulsed at window pulse_at
  // (0 = never) to confirm it is ignored while busy.
  task automatic run_scan(input logic [3:0] b, input int pulse_at, input string nm);
    int cnt;
    logic [7:0] ea;
    for (int i = 0; i < 9; i++) mem[int'(b) * 9 + i] = board[i];
    modelo();
    @(negedge clock);
    base = b;
    iniciar = 1'b1;
    cnt = 0;
    forever begin
      @(negedge clock);
      cnt++;
      iniciar = (cnt == pulse_at);
      if (cnt == 1) base = 4'($urandom);
      ea = (cnt <= 9) ? 8'(int'(b) * 9 + cnt - 1) : 8'd0;
      checks++;
      if (endereco !== ea) begin
        errors++;
        $display("FAIL %s endereco window %0d: got %0d want %0d", nm, cnt, endereco, ea);
      end
      if (pronto === 1'b1) break;
      if (cnt >= 40) begin
        errors++;
        $display("FAIL %s timeout: no pronto after %0d cycles", nm, cnt);
        break;
      end
    end
    checks++;
    if (cnt !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", nm, cnt, exp_lat);
    end
    checks++;
    if (vencedor !== exp_v || empate !== exp_e || linha !== exp_l || ocupado !== 1'b1) begin
      errors++;
      $display("FAIL %s result: got v=%b e=%b l=%0d oc=%b want v=%b e=%b l=%0d oc=1",
               nm, vencedor, empate, linha, ocupado, exp_v, exp_e, exp_l);
    end
    iniciar = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clock);
      checks++;
      if (pronto !== 1'b0 || ocupado !== 1'b0 || db_estado !== 4'h0 ||
          vencedor !== exp_v || empate !== exp_e || linha !== exp_l) begin
        errors++;
        $display("FAIL %s hold %0d: got p=%b oc=%b st=%h v=%b e=%b l=%0d want p=0 oc=0 st=0 v=%b e=%b l=%0d",
                 nm, j, pronto, ocupado, db_estado, vencedor, empate, linha, exp_v, exp_e, exp_l);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    iniciar = 1'b0;
    base = 4'd0;
    repeat (3) @(negedge clock);
    checks++;
    if ({endereco, ocupado, pronto, vencedor, empate, linha, db_estado} !== 20'd0) begin
      errors++;
      $display("FAIL reset outputs: got end=%0d oc=%b p=%b v=%b e=%b l=%0d st=%h want all 0",
               endereco, ocupado, pronto, vencedor, empate, linha, db_estado);
    end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_directed();
    set_board(2,2,2, 0,0,0, 0,0,0);
    run_scan(4'd0, 0, "row0_x");
    set_board(0,0,1, 0,1,0, 1,0,0);
    run_scan(4'd9, 0, "antidiag_o_macro");
    set_board(1,2,1, 1,2,2, 2,1,3);
    run_scan(4'd4, 0, "full_draw");
    set_board(3,3,3, 0,0,0, 0,0,0);
    run_scan(4'd2, 0, "blocked_row");
    set_board(3,3,3, 3,3,3, 3,3,3);
    run_scan(4'd7, 0, "all_blocked_draw");
    set_board(2,2,2, 2,0,0, 2,0,0);
    run_scan(4'd1, 0, "row_and_col");
    set_board(1,2,0, 1,2,0, 0,2,1);
    run_scan(4'd15, 0, "col4_x_base15");
  endtask

  task automatic test_back_to_back_random();
    for (int t = 0; t < 40; t++) begin
      logic [1:0] pat;
      for (int i = 0; i < 9; i++) board[i] = 2'($urandom_range(0, 3));
      // Plant a line on some boards so wins on every index get exercised.
      if (t % 3 != 0) begin
        int ln;
        ln = $urandom_range(0, 7);
        pat = 2'($urandom_range(1, 2));
        for (int j = 0; j < 3; j++) board[lt[ln][j]] = pat;
      end
      run_scan(4'($urandom_range(0, 15)), 0, "random");
    end
  endtask

  task automatic test_start_ignored();
    int npr;
    set_board(1,2,1, 2,1,2, 2,1,2);
    run_scan(4'd3, 12, "start_in_avalia");
    npr = 0;
    repeat (25) begin
      @(negedge clock);
      if (pronto === 1'b1) npr++;
    end
    checks++;
    if (npr !== 0) begin
      errors++;
      $display("FAIL start_in_avalia extra pronto: got %0d want 0", npr);
    end
  endtask

  task automatic test_reset_mid_scan();
    int npr;
    set_board(2,2,2, 1,1,0, 0,0,0);
    for (int i = 0; i < 9; i++) mem[5 * 9 + i] = board[i];
    @(negedge clock);
    base = 4'd5;
    iniciar = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      iniciar = 1'b0;
    end
    // Window 5 is LEITURA with k=4.
    checks++;
    if (endereco !== 8'd49) begin
      errors++;
      $display("FAIL midreset pre endereco: got %0d want 49", endereco);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({endereco, ocupado, pronto, vencedor, empate, linha, db_estado} !== 20'd0) begin
      errors++;
      $display("FAIL midreset outputs: got end=%0d oc=%b p=%b v=%b e=%b l=%0d st=%h want all 0",
               endereco, ocupado, pronto, vencedor, empate, linha, db_estado);
    end
    @(negedge clock);
    reset_n = 1'b1;
    npr = 0;
    repeat (25) begin
      @(negedge clock);
      if (pronto === 1'b1 || ocupado === 1'b1) npr++;
    end
    checks++;
    if (npr !== 0) begin
      errors++;
      $display("FAIL midreset activity after abort: got %0d busy cycles want 0", npr);
    end
    run_scan(4'd5, 0, "after_midreset");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 2'($urandom_range(0, 3));
    test_reset();
    test_directed();
    test_start_ignored();
    test_reset_mid_scan();
    test_back_to_back_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
